stim_serializer: RTL
====================

STIM_SERIALIZER -- requirements
Module: stim_serializer

Interface
REQ-001 Parameter WIDTH, default 32, is the stimulus word length in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 load  input  1  producer request: data is valid this cycle.
REQ-005 data  input  WIDTH  stimulus word, transmitted MSB first.
REQ-006 ready  output  1  block can accept a word this cycle; transfer occurs when load && ready.
REQ-007 en  input  1  advance strobe; when low the serial output is held.
REQ-008 w  output  1  serial bit that drives the downstream FSM's w input.
REQ-009 w_valid  output  1  w carries a real stimulus bit.
REQ-010 done  output  1  one-cycle pulse after the last bit of a word is consumed.
REQ-011 busy  output  1  high while in SHIFT or while a pending word is held.

Function
REQ-012 The block has two states: IDLE and SHIFT. It holds a WIDTH-bit shift register, a bit counter of clog2(WIDTH) bits, and a one-entry pending buffer with a pending_full flag.
REQ-013 ready = !pending_full, driven from registered state only (no combinational path from load or en).
REQ-014 IDLE with an accepted word: the shift register loads data, the counter clears, and the state becomes SHIFT. The first bit appears on w in the next cycle (latency 1).
REQ-015 SHIFT with an accepted word: the word goes to the pending buffer and pending_full sets. The active word is not disturbed.
REQ-016 In SHIFT: w = shift register MSB and w_valid = 1. In IDLE: w = 0 and w_valid = 0.
REQ-017 SHIFT with en=1 and counter < WIDTH-1: shift left one bit (zero fill) and increment the counter.
REQ-018 SHIFT with en=0: the shift register, counter and state hold. w stays stable.
REQ-019 SHIFT with en=1 and counter == WIDTH-1 (last bit consumed): done=1 on the next cycle. Then:
 - if pending_full, the pending word moves to the shift register, the counter clears, pending_full clears, and the state stays SHIFT. There is no bubble: the next word's MSB follows directly.
 - otherwise the state becomes IDLE.
REQ-020 Last bit consumed while a load is accepted in the same cycle:
 - with pending empty (ready=1), the new word goes straight to the shift register, as in REQ-019.
 - with pending full, ready=0, so no acceptance occurs.
REQ-021 done is a single-cycle pulse per word, including back-to-back words. done is never asserted in IDLE without a preceding last bit.
REQ-022 busy = (state == SHIFT) || pending_full.
REQ-023 load while ready=0 is ignored; data is not sampled.

Reset
REQ-024 While rst_n=0 at a clock edge:
 - state becomes IDLE; shift register, counter and pending buffer clear; pending_full=0.
 - outputs are w=0, w_valid=0, done=0, busy=0, ready=1.
REQ-025 Reset mid-word aborts the word with no done pulse. The pending word is discarded. load on the reset cycle is ignored.

Structure
REQ-026 Package stim_pkg holds the state enum (IDLE, SHIFT) and the constant STIM_WIDTH_DEFAULT = 32. The module imports both.
REQ-027 The block is a single module with no sub-modules. The counter width is derived from WIDTH by $clog2.

Verification
REQ-028 Reset, then load 0xACE3C0FD with en=1 throughout -> w shows 1,0,1,0,1,1,0,0,... MSB first for 32 cycles starting 1 cycle after acceptance, with w_valid high for all 32; done pulses once, on the cycle after bit 31; then w_valid=0 and busy=0.
REQ-029 Back-to-back: load 0xFFFF0000, then 0x0000FFFF while shifting -> ready drops after the second acceptance; 64 contiguous valid bits with no gap; done pulses twice, 32 cycles apart.
REQ-030 Stall: en=0 for 5 cycles mid-word -> w and counter hold, total time = 32 + 5 cycles, and the bit order is unchanged.
REQ-031 Reset asserted at bit 10 with a pending word held -> next cycle w_valid=0, ready=1, busy=0, and no done pulse.
REQ-032 Pending full: a third load attempted while ready=0 -> ignored; only two words appear on w.
REQ-033 System check: connect w to the downstream FSM's w input with a shared clk and rst_n, drive the lab test word 0xACE3C0FD, and compare the FSM's out1 cycle by cycle against the FSM's golden output sequence.

Source files
------------

// File: rtl/stim_pkg.sv
// Shared types and constants for the stimulus serializer.
package stim_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int STIM_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/stim_serializer.sv
// Parallel-to-serial stimulus driver: words go out MSB first on w, with a
// one-entry pending buffer so back-to-back words stream without a bubble.
module stim_serializer
  import stim_pkg::*;
#(
  parameter int WIDTH = STIM_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  input  logic             en,
  output logic             w,
  output logic             w_valid,
  output logic             done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             done_q, done_d;

  logic accept;
  logic at_last;

  always_comb begin
    accept  = load && !pend_full_q;
    at_last = (state_q == SHIFT) && en && (cnt_q == LAST);

    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A word accepted on the last-bit cycle bypasses the pending buffer.
        if (accept && !at_last) begin
          pend_d      = data;
          pend_full_d = 1'b1;
        end
        if (en) begin
          if (!at_last) begin
            sreg_d = sreg_q << 1;
            cnt_d  = cnt_q + CW'(1);
          end else begin
            done_d = 1'b1;
            cnt_d  = '0;
            if (pend_full_q) begin
              sreg_d      = pend_q;
              pend_full_d = 1'b0;
            end else if (accept) begin
              sreg_d = data;
            end else begin
              sreg_d  = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      done_q      <= done_d;
    end
  end

  assign ready   = !pend_full_q;
  assign w_valid = (state_q == SHIFT);
  assign w       = (state_q == SHIFT) && sreg_q[WIDTH-1];
  assign done    = done_q;
  assign busy    = (state_q == SHIFT) || pend_full_q;

endmodule
